// File: rtl/ice51_boot_loader.sv
// ice51_boot_loader: 8N1 UART receiver and program loader for the ice51 core.
// The first MEM_SIZE received bytes are written to program memory at sequential
// addresses while the core is held in reset. Later bytes go to the core's
// serial receive register.
// Build option: define ICE51_PRELOAD_EN to start in the run state. Memory is then
// assumed to be loaded externally, and every byte is forwarded to the core.
module ice51_boot_loader #(
   parameter int BAUD_DIV = 104,
   parameter int MEM_SIZE = 1024,
   parameter int ADDR_W   = 10
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_uart_rx,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [7:0]        o_mem_data,
   output logic              o_core_nrst,
   output logic              o_loaded,
   output logic              o_rx_valid,
   output logic [7:0]        o_rx_data,
   output logic              o_frame_err
);

   localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(BAUD_DIV / 2 - 1);
   localparam logic [CNT_W-1:0]  FULL_M1 = CNT_W'(BAUD_DIV - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_SIZE - 1);

   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE} rx_state_t;
   typedef enum logic {LD_LOAD, LD_RUN} ld_state_t;

`ifdef ICE51_PRELOAD_EN
   localparam ld_state_t LD_RESET = LD_RUN;
`else
   localparam ld_state_t LD_RESET = LD_LOAD;
`endif

   logic             sync1_q, rxs_q;
   rx_state_t        rx_state_q, rx_state_d;
   logic [CNT_W-1:0] baud_q, baud_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             byte_done;
   logic             frame_err_q, frame_err_d;

   ld_state_t        ld_state_q, ld_state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic             mem_we_q, mem_we_d;
   logic [7:0]       mem_data_q, mem_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic [7:0]       rx_data_q, rx_data_d;

   // Two-flop synchroniser for the asynchronous RX pin; idles high.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sync1_q <= 1'b1;
         rxs_q   <= 1'b1;
      end else begin
         sync1_q <= i_uart_rx;
         rxs_q   <= sync1_q;
      end
   end

   // Receiver state, bit and baud counters, shift register and error pulse.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rx_state_q  <= RX_IDLE;
         baud_q      <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
      end else begin
         rx_state_q  <= rx_state_d;
         baud_q      <= baud_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Receiver next state: a half-bit wait reaches mid start bit, then full-bit steps.
   always_comb begin
      rx_state_d  = rx_state_q;
      baud_d      = baud_q + 1'b1;
      bit_d       = bit_q;
      shift_d     = shift_q;
      byte_done   = 1'b0;
      frame_err_d = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            baud_d = '0;
            if (!rxs_q) rx_state_d = RX_START;
         end
         RX_START: begin
            if (baud_q == HALF_M1) begin
               baud_d     = '0;
               bit_d      = '0;
               // If the line is already high again, the low level was a glitch.
               rx_state_d = rxs_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (baud_q == FULL_M1) begin
               baud_d  = '0;
               shift_d = {rxs_q, shift_q[7:1]};
               if (bit_q == 3'd7) rx_state_d = RX_STOP;
               else               bit_d = bit_q + 3'd1;
            end
         end
         RX_STOP: begin
            if (baud_q == FULL_M1) begin
               baud_d = '0;
               if (rxs_q) begin
                  byte_done  = 1'b1;
                  rx_state_d = RX_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  rx_state_d  = RX_WAIT_IDLE;
               end
            end
         end
         RX_WAIT_IDLE: begin
            baud_d = '0;
            if (rxs_q) rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // Loader state, write pointer and registered output strobes.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ld_state_q <= LD_RESET;
         ptr_q      <= '0;
         mem_we_q   <= 1'b0;
         mem_data_q <= '0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= '0;
      end else begin
         ld_state_q <= ld_state_d;
         ptr_q      <= ptr_d;
         mem_we_q   <= mem_we_d;
         mem_data_q <= mem_data_d;
         rx_valid_q <= rx_valid_d;
         rx_data_q  <= rx_data_d;
      end
   end

   // Loader next state. The pointer advances in the cycle after the write pulse.
   // This keeps o_mem_addr equal to the written address while the pulse is high.
   always_comb begin
      ld_state_d = ld_state_q;
      ptr_d      = ptr_q;
      mem_we_d   = 1'b0;
      mem_data_d = mem_data_q;
      rx_valid_d = 1'b0;
      rx_data_d  = rx_data_q;
      case (ld_state_q)
         LD_LOAD: begin
            if (mem_we_q) begin
               if (ptr_q == LAST_ADDR) begin
                  ptr_d      = '0;
                  ld_state_d = LD_RUN;
               end else begin
                  ptr_d = ptr_q + 1'b1;
               end
            end
            if (byte_done) begin
               mem_we_d   = 1'b1;
               mem_data_d = shift_q;
            end
         end
         LD_RUN: begin
            if (byte_done) begin
               rx_valid_d = 1'b1;
               rx_data_d  = shift_q;
            end
         end
         default: ld_state_d = LD_RESET;
      endcase
   end

   assign o_mem_we    = mem_we_q;
   assign o_mem_addr  = ptr_q;
   assign o_mem_data  = mem_data_q;
   assign o_loaded    = (ld_state_q == LD_RUN);
   assign o_core_nrst = (ld_state_q == LD_RUN);
   assign o_rx_valid  = rx_valid_q;
   assign o_rx_data   = rx_data_q;
   assign o_frame_err = frame_err_q;

endmodule

// File: doc/ice51_boot_loader.md
# ice51_boot_loader

UART receive front end and program loader for the ice51 core. It deserialises 8N1 bytes from the board UART RX pin and writes the first MEM_SIZE bytes after reset into program memory at sequential addresses, holding the core in reset while it does so. After the last byte it releases the core and forwards all later received bytes to the core's serial receive register.

## Interface

Parameters:
- BAUD_DIV, 104 — clock cycles per UART bit (12 MHz / 115200, truncated).
- MEM_SIZE, 1024 — number of bytes loaded before the core is released.
- ADDR_W, 10 — program memory address width; must satisfy 2^ADDR_W >= MEM_SIZE.

Ports:
- i_clk  in  1  — system clock, 12 MHz.
- i_rst  in  1  — asynchronous reset, active-high.
- i_uart_rx  in  1  — UART RX pin, idle high, asynchronous to i_clk.
- o_mem_we  out  1  — program memory write strobe, one-cycle pulse.
- o_mem_addr  out  ADDR_W  — program memory write address.
- o_mem_data  out  8  — program memory write data.
- o_core_nrst  out  1  — core reset, active-low; low while loading.
- o_loaded  out  1  — high once all MEM_SIZE bytes are written; stays high until reset.
- o_rx_valid  out  1  — one-cycle pulse: post-load byte available to core.
- o_rx_data  out  8  — post-load byte; held until the next o_rx_valid.
- o_frame_err  out  1  — one-cycle pulse when a byte's stop bit samples low.

## Operation

- The RX pin passes through a 2-flop synchroniser. The receiver uses only the synchronised signal rxs.
- Receiver FSM (IDLE, START, DATA, STOP, WAIT_IDLE); one bit counter (0..7) and one baud counter (0..BAUD_DIV-1):
  - IDLE: on rxs==0, go to START with the baud counter cleared.
  - START: after BAUD_DIV/2 cycles, sample rxs. If 0, go to DATA. If 1, treat it as a glitch and return to IDLE with no output.
  - DATA: sample every BAUD_DIV cycles, LSB first, into a shift register. After the 8th sample, go to STOP.
  - STOP: sample after BAUD_DIV cycles. If 1, raise byte_done internally and go to IDLE. If 0, pulse o_frame_err, discard the byte and go to WAIT_IDLE.
  - WAIT_IDLE: go to IDLE when rxs==1.
- Loader FSM (LOAD, RUN):
  - LOAD: each byte_done drives o_mem_we=1 with o_mem_data=byte and o_mem_addr=ptr, then increments ptr. The write of address MEM_SIZE-1 moves the FSM to RUN.
  - RUN: o_loaded=1, o_core_nrst=1. Each byte_done drives o_rx_valid=1 and o_rx_data=byte. o_mem_we stays 0.
- Framing-errored bytes are never written or forwarded, and ptr does not advance.
- o_mem_addr holds ptr at all times. After the final write it wraps to 0 and holds there.

## Timing

- Reset values:
  - o_mem_we=0, o_mem_addr=0, o_mem_data=0, o_loaded=0, o_core_nrst=0.
  - o_rx_valid=0, o_rx_data=0, o_frame_err=0.
  - Receiver in IDLE; loader in LOAD.
- Latency: the stop-bit sample occurs BAUD_DIV/2 + 9*BAUD_DIV cycles after rxs falls; rxs lags the pin by 2 cycles. The o_mem_we or o_rx_valid pulse is registered and appears 1 cycle after the stop-bit sample.
- o_loaded and o_core_nrst rise in the cycle after the final o_mem_we pulse.
- A new start bit is accepted in the cycle after the return to IDLE, so back-to-back frames with a single stop bit are received.
- Reset mid-frame or mid-load: all state returns to reset values immediately; the next valid byte is written to address 0.
- A low pulse on rxs shorter than BAUD_DIV/2 cycles produces no output of any kind.

## Configuration

- ICE51_PRELOAD_EN defined: the loader FSM resets into RUN.
  - o_loaded=1 and o_core_nrst=1 from reset.
  - o_mem_we is tied 0 and every received byte goes to o_rx_valid/o_rx_data.
  - Memory is initialised externally.
- ICE51_PRELOAD_EN undefined: behaviour as described above.

## Test plan

- Full load: send 1024 bytes with value addr[7:0] at 115200 baud. Required: exactly 1024 o_mem_we pulses with matching addr/data; o_loaded and o_core_nrst rise 1 cycle after the final pulse.
- Post-load forwarding: after the full load, send 0xA5. Required: one o_rx_valid pulse with o_rx_data=0xA5; no o_mem_we pulse.
- Glitch rejection: drive RX low for 20 cycles, then high. Required: no o_mem_we, o_rx_valid or o_frame_err; the next valid byte 0x3C is written at the expected address.
- Framing error: send 0x55 with the stop bit low, then 0x77 normally. Required: one o_frame_err pulse; 0x77 is written at the address 0x55 would have used.
- Reset mid-load: assert i_rst after 500 bytes, release it, send 0x12. Required: write to address 0 with data 0x12; o_loaded=0.
- Preload build (ICE51_PRELOAD_EN defined): send 0xC3 after reset. Required: o_loaded=1 from reset, o_rx_valid pulse with 0xC3, no o_mem_we pulse.
